// File: rtl/msr_reader.sv
// Initiator for the measurement-request handshake: raises data_req, waits for a
// synchronised data_rdy, lets msr_data settle, then reports the sample and its delta.
module msr_reader #(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              ref_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              data_rdy,
  input  logic [DATA_W-1:0] msr_data,
  output logic              data_req,
  output logic              busy,
  output logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] delta,
  output logic              sample_valid,
  output logic              delta_valid,
  output logic              timeout_err
);

  localparam int T_MAX   = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_RDY, S_SETTLE, S_WAIT_DROP} state_t;

  state_t              state_reg, state_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic                data_req_reg, data_req_next;
  logic [DATA_W-1:0]   sample_reg, sample_next;
  logic [DATA_W-1:0]   delta_reg, delta_next;
  logic                have_prev_reg, have_prev_next;
  logic                sample_valid_reg, sample_valid_next;
  logic                delta_valid_reg, delta_valid_next;
  logic                timeout_err_reg, timeout_err_next;
  logic                sync_reg [SYNC_STAGES];
  logic                rdy_s;

  // data_rdy comes from another clock domain; only the last stage is used.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) sync_reg[0] <= 1'b0;
    else        sync_reg[0] <= data_rdy;
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) sync_reg[gi] <= 1'b0;
        else        sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  assign rdy_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      timer_reg        <= '0;
      data_req_reg     <= 1'b0;
      sample_reg       <= '0;
      delta_reg        <= '0;
      have_prev_reg    <= 1'b0;
      sample_valid_reg <= 1'b0;
      delta_valid_reg  <= 1'b0;
      timeout_err_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      timer_reg        <= timer_next;
      data_req_reg     <= data_req_next;
      sample_reg       <= sample_next;
      delta_reg        <= delta_next;
      have_prev_reg    <= have_prev_next;
      sample_valid_reg <= sample_valid_next;
      delta_valid_reg  <= delta_valid_next;
      timeout_err_reg  <= timeout_err_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    timer_next        = timer_reg + TIMER_W'(1);
    data_req_next     = data_req_reg;
    sample_next       = sample_reg;
    delta_next        = delta_reg;
    have_prev_next    = have_prev_reg;
    sample_valid_next = 1'b0;
    delta_valid_next  = 1'b0;
    timeout_err_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        timer_next = '0;
        if (start) begin
          state_next    = S_WAIT_RDY;
          data_req_next = 1'b1;
        end
      end
      S_WAIT_RDY: begin
        if (rdy_s) begin
          state_next = S_SETTLE;
          timer_next = '0;
        end else if (timer_reg == TIMER_W'(TIMEOUT - 1)) begin
          state_next       = S_WAIT_DROP;
          timer_next       = '0;
          data_req_next    = 1'b0;
          timeout_err_next = 1'b1;
        end
      end
      S_SETTLE: begin
        // Capture happens regardless of rdy_s; a dropped ready here is not checked.
        if (timer_reg == TIMER_W'(SETTLE - 1)) begin
          sample_next       = msr_data;
          delta_next        = msr_data - sample_reg;
          sample_valid_next = 1'b1;
          delta_valid_next  = have_prev_reg;
          have_prev_next    = 1'b1;
          data_req_next     = 1'b0;
          state_next        = S_WAIT_DROP;
          timer_next        = '0;
        end
      end
      S_WAIT_DROP: begin
        if (!rdy_s) begin
          state_next = S_IDLE;
          timer_next = '0;
        end else if (timer_reg == TIMER_W'(TIMEOUT - 1)) begin
          state_next       = S_IDLE;
          timer_next       = '0;
          timeout_err_next = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign data_req     = data_req_reg;
  assign busy         = (state_reg != S_IDLE);
  assign sample       = sample_reg;
  assign delta        = delta_reg;
  assign sample_valid = sample_valid_reg;
  assign delta_valid  = delta_valid_reg;
  assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_msr_reader.sv
// Bench for msr_reader: a free-running counter responder answers each request,
// directed scenarios check captures, deltas, wrap, timeout and reset behaviour.
module tb_msr_reader;
  localparam int DATA_W  = 24;
  localparam int TIMEOUT = 255;

  logic              ref_clk = 1'b0;
  logic              rst_n   = 1'b0;
  logic              start   = 1'b0;
  logic              data_rdy = 1'b0;
  logic [DATA_W-1:0] msr_data;
  logic              data_req, busy, sample_valid, delta_valid, timeout_err;
  logic [DATA_W-1:0] sample, delta;

  msr_reader #(.DATA_W(DATA_W), .SYNC_STAGES(2), .SETTLE(2), .TIMEOUT(TIMEOUT)) dut (
    .ref_clk(ref_clk), .rst_n(rst_n), .start(start), .data_rdy(data_rdy),
    .msr_data(msr_data), .data_req(data_req), .busy(busy), .sample(sample),
    .delta(delta), .sample_valid(sample_valid), .delta_valid(delta_valid),
    .timeout_err(timeout_err)
  );

  always #5 ref_clk = ~ref_clk;

  // Responder model
  logic [DATA_W-1:0] cnt = '0, latched = '0, ld_val = '0;
  logic ld_en = 1'b0, resp_en = 1'b1, req_d = 1'b0, rdy_pend = 1'b0;
  int   cyc = 0;

  assign msr_data = latched;

  always @(posedge ref_clk) begin
    cyc   <= cyc + 1;
    req_d <= data_req;
    cnt   <= ld_en ? ld_val : cnt + 1'b1;
    if (data_req && !req_d) begin
      latched  <= cnt;
      rdy_pend <= resp_en;
    end else begin
      rdy_pend <= 1'b0;
    end
    if (!data_req)     data_rdy <= 1'b0;
    else if (rdy_pend) data_rdy <= 1'b1;
  end

  // Output monitor, sampled mid-cycle
  int sv_cnt = 0, dv_cnt = 0, to_cnt = 0, rise_cnt = 0, req_hi_cnt = 0;
  logic req_mon = 1'b0, last_dv = 1'b0;

  always @(negedge ref_clk) begin
    if (sample_valid) begin
      sv_cnt  <= sv_cnt + 1;
      last_dv <= delta_valid;
      $display("[%0t] capture sample=0x%06h delta=0x%06h delta_valid=%0b",
               $time, sample, delta, delta_valid);
    end
    if (delta_valid) dv_cnt <= dv_cnt + 1;
    if (timeout_err) begin
      to_cnt <= to_cnt + 1;
      $display("[%0t] handshake timeout", $time);
    end
    if (data_req && !req_mon) rise_cnt <= rise_cnt + 1;
    if (data_req) req_hi_cnt <= req_hi_cnt + 1;
    req_mon <= data_req;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is high for exactly one rising edge.
  task automatic do_start(input logic ld, input logic [DATA_W-1:0] v, output int t);
    ld_en  = ld;
    ld_val = v;
    start  = 1'b1;
    t      = cyc;
    @(negedge ref_clk);
    ld_en  = 1'b0;
    start  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge ref_clk);
    @(negedge ref_clk);
    check_eq("wait_idle_busy", busy, 0);
  endtask

  int t0, t1, sv0, to0, rise0, hi0;

  initial begin
    // 1: reset and idle
    repeat (3) @(negedge ref_clk);
    rst_n = 1'b1;
    repeat (10) @(negedge ref_clk);
    check_eq("rst_data_req", data_req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_sample", sample, 0);
    check_eq("rst_delta", delta, 0);
    check_eq("rst_pulses", sv_cnt + to_cnt, 0);

    // 2: single capture with counter at 0x000100
    do_start(1'b1, 24'h000100, t0);
    wait_idle(100);
    check_eq("t2_sample", sample, 32'h000100);
    check_eq("t2_sv_count", sv_cnt, 1);
    check_eq("t2_delta_valid", last_dv, 0);
    check_eq("t2_rdy_low_at_idle", data_rdy, 0);
    check_eq("t2_one_request", rise_cnt, 1);

    // 3: two starts exactly 1000 cycles apart
    do_start(1'b0, '0, t0);
    wait_idle(100);
    while (cyc < t0 + 1000) @(negedge ref_clk);
    do_start(1'b0, '0, t1);
    wait_idle(100);
    check_eq("t3_spacing", t1 - t0, 1000);
    check_eq("t3_delta", delta, 32'h0003E8);
    check_eq("t3_delta_valid", last_dv, 1);

    // 4: wrap-around deltas
    do_start(1'b1, 24'hFFFFFE, t0);
    wait_idle(100);
    do_start(1'b1, 24'h000002, t0);
    wait_idle(100);
    check_eq("t4_sample_a", sample, 32'h000002);
    check_eq("t4_delta_a", delta, 32'h000004);
    do_start(1'b1, 24'hFFFFF0, t0);
    wait_idle(100);
    check_eq("t4_sample_b", sample, 32'hFFFFF0);
    check_eq("t4_delta_b", delta, 32'hFFFFEE);

    // 5: responder silent -> timeout
    resp_en = 1'b0;
    sv0 = sv_cnt; to0 = to_cnt; hi0 = req_hi_cnt;
    do_start(1'b0, '0, t0);
    wait_idle(TIMEOUT + 50);
    check_eq("t5_timeout_pulses", to_cnt - to0, 1);
    check_eq("t5_no_sample", sv_cnt - sv0, 0);
    check_eq("t5_data_req_low", data_req, 0);
    check_eq("t5_req_high_cycles", req_hi_cnt - hi0, TIMEOUT);
    check_eq("t5_sample_kept", sample, 32'hFFFFF0);

    // 6a: asynchronous reset in WAIT_RDY
    sv0 = sv_cnt; to0 = to_cnt;
    do_start(1'b0, '0, t0);
    repeat (5) @(negedge ref_clk);
    check_eq("t6_req_before_rst", data_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_req_async_clear", data_req, 0);
    check_eq("t6_busy_async_clear", busy, 0);
    @(negedge ref_clk);
    rst_n   = 1'b1;
    resp_en = 1'b1;
    @(negedge ref_clk);
    check_eq("t6_no_pulse", (sv_cnt - sv0) + (to_cnt - to0), 0);
    check_eq("t6_sample_cleared", sample, 0);
    do_start(1'b1, 24'h000500, t0);
    wait_idle(100);
    check_eq("t6_sample_after_rst", sample, 32'h000500);
    check_eq("t6_no_prev_after_rst", last_dv, 0);

    // 6b: start pulses while busy are ignored
    sv0 = sv_cnt; rise0 = rise_cnt;
    do_start(1'b1, 24'h000600, t0);
    repeat (3) @(negedge ref_clk);
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    repeat (4) @(negedge ref_clk);
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    wait_idle(100);
    repeat (5) @(negedge ref_clk);
    check_eq("t6_single_request", rise_cnt - rise0, 1);
    check_eq("t6_single_capture", sv_cnt - sv0, 1);
    check_eq("t6_sample_busy", sample, 32'h000600);
    check_eq("t6_delta_busy", delta, 32'h000100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
